// File: rtl/vga_line_fetcher.sv
`default_nettype none
// ============================================================================
// vga_line_fetcher : fetches one Atari scanline from SRAM into a ping-pong line
//                    store and serves pixels to the VGA colour path.
// Revision 1.0
// ============================================================================
module vga_line_fetcher #(
  parameter int LINE_W = 160,
  parameter int XW     = 8,
  parameter int YW     = 9,
  parameter int HSHIFT = 2
) (
  input  logic          iCLK,
  input  logic          iRST_N,
  input  logic          iLineStart,
  input  logic [YW-1:0] iLineY,
  output logic          oSRAM_REQ,
  output logic [17:0]   oSRAM_ADDR,
  input  logic          iSRAM_GNT,
  input  logic [15:0]   iSRAM_DQ,
  input  logic [9:0]    iCoord_X,
  output logic [7:0]    oPixel,
  output logic          oBusy,
  output logic          oOverrun
);

  localparam logic [XW-1:0] X_LAST   = XW'(LINE_W - 1);
  localparam logic [9:0]    AX_LIMIT = 10'(LINE_W);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t        state_q;
  logic          req_q;
  logic          rd_bank_q;
  logic          gnt_dly_q;
  logic          overrun_q;
  logic [XW-1:0] x_q;
  logic [XW-1:0] x_dly_q;
  logic [YW-1:0] y_q;
  logic [7:0]    pixel_q;
  logic [7:0]    line_mem [0:1][0:LINE_W-1];
  logic [9:0]    ax;
  logic          unused_dq_hi;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q   <= S_IDLE;
      req_q     <= 1'b0;
      rd_bank_q <= 1'b0;
      gnt_dly_q <= 1'b0;
      overrun_q <= 1'b0;
      x_q       <= '0;
      x_dly_q   <= '0;
      y_q       <= '0;
    end else begin
      overrun_q <= 1'b0;
      gnt_dly_q <= 1'b0;
      x_dly_q   <= x_q;
      // A new line always wins; clearing gnt_dly_q drops any beat still in flight.
      if (iLineStart) begin
        overrun_q <= (state_q != S_IDLE);
        rd_bank_q <= ~rd_bank_q;
        y_q       <= iLineY;
        x_q       <= '0;
        req_q     <= 1'b1;
        state_q   <= S_FETCH;
      end else begin
        case (state_q)
          S_FETCH: begin
            if (iSRAM_GNT) begin
              gnt_dly_q <= 1'b1;
              x_q       <= x_q + XW'(1);
              if (x_q == X_LAST) begin
                req_q   <= 1'b0;
                state_q <= S_DRAIN;
              end
            end
          end
          S_DRAIN: state_q <= S_IDLE;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge iCLK) begin
    if (gnt_dly_q) begin
      line_mem[~rd_bank_q][x_dly_q] <= iSRAM_DQ[7:0];
    end
  end

  assign ax = iCoord_X >> HSHIFT;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      pixel_q <= '0;
    end else if (ax < AX_LIMIT) begin
      pixel_q <= line_mem[rd_bank_q][ax[XW-1:0]];
    end else begin
      pixel_q <= '0;
    end
  end

  assign unused_dq_hi = ^iSRAM_DQ[15:8];

  assign oSRAM_REQ  = req_q;
  assign oSRAM_ADDR = 18'({x_q, y_q});
  assign oPixel     = pixel_q;
  assign oBusy      = (state_q != S_IDLE);
  assign oOverrun   = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_line_fetcher.sv
`default_nettype none
// ============================================================================
// tb_vga_line_fetcher : directed self-checking bench for vga_line_fetcher.
// Revision 1.0
// ============================================================================
module tb_vga_line_fetcher;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        line_start = 1'b0;
  logic [8:0]  line_y = '0;
  logic        gnt = 1'b0;
  logic [15:0] dq;
  logic [9:0]  coord = '0;
  logic        req;
  logic [17:0] addr;
  logic [7:0]  pixel;
  logic        busy;
  logic        overrun;

  logic [7:0]  key = '0;
  logic [7:0]  last_d = '0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // SRAM model: data for a granted address appears the following cycle.
  always @(posedge clk) begin
    if (gnt && req) last_d <= addr[16:9] ^ key;
  end
  assign dq = {8'hE7, last_d};

  vga_line_fetcher dut (
    .iCLK       (clk),
    .iRST_N     (rst_n),
    .iLineStart (line_start),
    .iLineY     (line_y),
    .oSRAM_REQ  (req),
    .oSRAM_ADDR (addr),
    .iSRAM_GNT  (gnt),
    .iSRAM_DQ   (dq),
    .iCoord_X   (coord),
    .oPixel     (pixel),
    .oBusy      (busy),
    .oOverrun   (overrun)
  );

  function automatic logic [17:0] exp_addr(input int x, input int y);
    return 18'((x << 9) | y);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_line(input logic [8:0] y, input logic [7:0] k);
    line_y     = y;
    key        = k;
    line_start = 1'b1;
    step();
    line_start = 1'b0;
  endtask

  task automatic test_reset();
    int seen;
    rst_n = 1'b0; line_start = 1'b0; gnt = 1'b0; coord = 10'd700;
    repeat (3) step();
    checks++; if (req !== 1'b0)     begin errors++; $display("FAIL reset_req: got %b want 0", req); end
    checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (pixel !== 8'h00)  begin errors++; $display("FAIL reset_pixel: got %h want 00", pixel); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    checks++; if (addr !== 18'h0)   begin errors++; $display("FAIL reset_addr: got %h want 0", addr); end
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 1000; i++) begin
      step();
      if (req !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0) seen++;
    end
    checks++; if (seen != 0)       begin errors++; $display("FAIL idle_activity: got %0d active cycles want 0", seen); end
    checks++; if (pixel !== 8'h00) begin errors++; $display("FAIL idle_pixel: got %h want 00", pixel); end
  endtask

  task automatic test_full_fetch();
    int n, cyc;
    gnt = 1'b1;
    start_line(9'd37, 8'h5A);
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL fetch_no_overrun: got %b want 0", overrun); end
    n = 0; cyc = 1;
    while (busy && cyc < 400) begin
      if (req) begin
        checks++;
        if (addr !== exp_addr(n, 37)) begin errors++; $display("FAIL fetch_addr: got %h want %h", addr, exp_addr(n, 37)); end
        n++;
      end
      step(); cyc++;
    end
    gnt = 1'b0;
    checks++; if (cyc != 162) begin errors++; $display("FAIL fetch_cycles: got %0d want 162", cyc); end
    checks++; if (n != 160)   begin errors++; $display("FAIL fetch_reqs: got %0d want 160", n); end
  endtask

  task automatic test_gnt_throttle();
    int n, cyc, ax;
    logic [7:0] exp_pix;
    gnt = 1'b0;
    start_line(9'd38, 8'hC3);
    coord = 10'd40;
    step();
    checks++; if (pixel !== 8'h50) begin errors++; $display("FAIL pixel_latency: got %h want 50", pixel); end
    n = 0; cyc = 0;
    while (busy && cyc < 1000) begin
      if (req) begin
        checks++;
        if (addr !== exp_addr(n, 38)) begin errors++; $display("FAIL throttle_addr: got %h want %h", addr, exp_addr(n, 38)); end
      end
      gnt = (cyc % 3 == 2);
      if (gnt && req) n++;
      ax      = (cyc * 7) % 160;
      coord   = 10'(ax * 4 + cyc % 4);
      exp_pix = 8'(ax) ^ 8'h5A;
      step(); cyc++;
      checks++;
      if (pixel !== exp_pix) begin errors++; $display("FAIL read_during_fill: got %h want %h", pixel, exp_pix); end
    end
    gnt = 1'b0;
    checks++; if (cyc >= 1000) begin errors++; $display("FAIL throttle_timeout: got %0d cycles want <1000", cyc); end
    checks++; if (n != 160)    begin errors++; $display("FAIL throttle_grants: got %0d want 160", n); end
  endtask

  task automatic test_overrun();
    int cyc;
    logic [7:0] exp_pix;
    gnt = 1'b0;
    start_line(9'd39, 8'h96);
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL start_no_overrun: got %b want 0", overrun); end
    for (int i = 0; i < 160; i++) begin
      coord = 10'(i * 4 + i % 4);
      step();
      exp_pix = 8'(i) ^ 8'hC3;
      checks++;
      if (pixel !== exp_pix) begin errors++; $display("FAIL bank_b_pixel: x=%0d got %h want %h", i, pixel, exp_pix); end
      checks++;
      if (req !== 1'b1 || addr !== exp_addr(0, 39)) begin errors++; $display("FAIL addr_hold: got req=%b addr=%h want 1 %h", req, addr, exp_addr(0, 39)); end
    end
    coord = 10'd639;
    step();
    checks++; if (pixel !== 8'h5C) begin errors++; $display("FAIL pixel_639: got %h want 5c", pixel); end
    for (int c = 640; c < 800; c++) begin
      coord = 10'(c);
      step();
      checks++;
      if (pixel !== 8'h00) begin errors++; $display("FAIL pixel_offscreen: x=%0d got %h want 00", c, pixel); end
    end
    gnt = 1'b1;
    for (int i = 0; i < 80; i++) step();
    checks++; if (addr !== exp_addr(80, 39)) begin errors++; $display("FAIL pre_abort_addr: got %h want %h", addr, exp_addr(80, 39)); end
    start_line(9'd40, 8'h3C);
    gnt = 1'b0;
    checks++; if (overrun !== 1'b1)          begin errors++; $display("FAIL overrun_pulse: got %b want 1", overrun); end
    checks++; if (addr !== exp_addr(0, 40))  begin errors++; $display("FAIL restart_addr: got %h want %h", addr, exp_addr(0, 40)); end
    checks++; if (busy !== 1'b1 || req !== 1'b1) begin errors++; $display("FAIL restart_busy: got busy=%b req=%b want 1 1", busy, req); end
    step();
    checks++; if (overrun !== 1'b0)          begin errors++; $display("FAIL overrun_one_cycle: got %b want 0", overrun); end
    for (int i = 0; i < 160; i++) begin
      coord = 10'(i * 4);
      step();
      exp_pix = (i < 80) ? (8'(i) ^ 8'h96) : (8'(i) ^ 8'h5A);
      checks++;
      if (pixel !== exp_pix) begin errors++; $display("FAIL aborted_bank: x=%0d got %h want %h", i, pixel, exp_pix); end
    end
    start_line(9'd41, 8'hE1);
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_second: got %b want 1", overrun); end
    for (int i = 0; i < 160; i++) begin
      coord = 10'(i * 4 + 2);
      step();
      exp_pix = 8'(i) ^ 8'hC3;
      checks++;
      if (pixel !== exp_pix) begin errors++; $display("FAIL fill_bank_clean: x=%0d got %h want %h", i, pixel, exp_pix); end
    end
    gnt = 1'b1;
    cyc = 0;
    while (busy && cyc < 400) begin step(); cyc++; end
    gnt = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL line_e_timeout: got busy=%b want 0", busy); end
    start_line(9'd42, 8'h77);
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL start_after_done: got %b want 0", overrun); end
    for (int i = 0; i < 160; i++) begin
      coord = 10'(i * 4 + 1);
      step();
      exp_pix = 8'(i) ^ 8'hE1;
      checks++;
      if (pixel !== exp_pix) begin errors++; $display("FAIL line_e_pixel: x=%0d got %h want %h", i, pixel, exp_pix); end
    end
  endtask

  task automatic test_reset_mid_fetch();
    int seen, cyc;
    gnt = 1'b1;
    repeat (10) step();
    rst_n = 1'b0;
    #1;
    checks++; if (req !== 1'b0)     begin errors++; $display("FAIL midrst_req: got %b want 0", req); end
    checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL midrst_busy: got %b want 0", busy); end
    checks++; if (addr !== 18'h0)   begin errors++; $display("FAIL midrst_addr: got %h want 0", addr); end
    checks++; if (pixel !== 8'h00)  begin errors++; $display("FAIL midrst_pixel: got %h want 00", pixel); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (req !== 1'b0 || busy !== 1'b0) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL post_reset_idle: got %0d active cycles want 0", seen); end
    start_line(9'd43, 8'h11);
    checks++; if (overrun !== 1'b0 || addr !== exp_addr(0, 43)) begin errors++; $display("FAIL post_reset_start: got ovr=%b addr=%h want 0 %h", overrun, addr, exp_addr(0, 43)); end
    cyc = 1;
    while (busy && cyc < 400) begin step(); cyc++; end
    gnt = 1'b0;
    checks++; if (cyc != 162) begin errors++; $display("FAIL post_reset_cycles: got %0d want 162", cyc); end
  endtask

  initial begin
    test_reset();
    test_full_fetch();
    test_gnt_throttle();
    test_overrun();
    test_reset_mid_fetch();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "simulation time limit");
  end

endmodule
`default_nettype wire
